// File: rtl/sd_pattern_gen.sv
// rtl/sd_pattern_gen.sv - serial pattern stimulus generator for the sequence detector
module sd_pattern_gen #(
  parameter int PAT_W   = 8,
  parameter int DIV_W   = 4,
  parameter int REP_W   = 4,
  parameter int GAP_CYC = 2,
  parameter int HIT_W   = 4,
  localparam int LEN_W  = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [DIV_W-1:0] div,
  input  logic [REP_W-1:0] reps,
  input  logic             fin,
  output logic             xs,
  output logic             busy,
  output logic             bit_strobe,
  output logic             done,
  output logic [HIT_W-1:0] hits
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  logic [1:0]       state, state_n;
  logic [PAT_W-1:0] pat_q, pat_n;
  logic [LEN_W-1:0] len_q, len_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [REP_W-1:0] reps_q, reps_n;
  logic [LEN_W-1:0] k, k_n;
  logic [DIV_W-1:0] dcnt, dcnt_n;
  logic [REP_W-1:0] rcnt, rcnt_n;
  logic [GAP_W-1:0] gcnt, gcnt_n;

  logic [LEN_W-1:0] len_eff;
  logic [LEN_W-1:0] bit_idx;
  logic [PAT_W-1:0] pat_shifted;
  logic             xs_n;

  // Out-of-range lengths fall back to the full pattern width.
  always_comb begin
    len_eff = len;
    if (len == '0 || len > LEN_MAX) begin
      len_eff = LEN_MAX;
    end
  end

  always_comb begin
    state_n = state;
    pat_n   = pat_q;
    len_n   = len_q;
    div_n   = div_q;
    reps_n  = reps_q;
    k_n     = k;
    dcnt_n  = dcnt;
    rcnt_n  = rcnt;
    gcnt_n  = gcnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          pat_n   = pattern;
          len_n   = len_eff;
          div_n   = div;
          reps_n  = reps;
          k_n     = '0;
          dcnt_n  = '0;
          rcnt_n  = '0;
          gcnt_n  = '0;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (dcnt != div_q) begin
          dcnt_n = dcnt + 1'b1;
        end else begin
          dcnt_n = '0;
          if (k != len_q - LEN_ONE) begin
            k_n = k + LEN_ONE;
          end else begin
            k_n = '0;
            if (rcnt == reps_q) begin
              state_n = S_DONE;
            end else begin
              rcnt_n = rcnt + 1'b1;
              gcnt_n = '0;
              state_n = (GAP_CYC == 0) ? S_SHIFT : S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (gcnt == GAP_LAST) begin
          gcnt_n  = '0;
          state_n = S_SHIFT;
        end else begin
          gcnt_n = gcnt + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Outputs are computed from next-state values so they line up with the state register.
  always_comb begin
    bit_idx     = len_n - LEN_ONE - k_n;
    pat_shifted = pat_n >> bit_idx;
    xs_n        = (state_n == S_SHIFT) ? pat_shifted[0] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      pat_q      <= '0;
      len_q      <= '0;
      div_q      <= '0;
      reps_q     <= '0;
      k          <= '0;
      dcnt       <= '0;
      rcnt       <= '0;
      gcnt       <= '0;
      xs         <= 1'b0;
      busy       <= 1'b0;
      bit_strobe <= 1'b0;
      done       <= 1'b0;
      hits       <= '0;
    end else begin
      state      <= state_n;
      pat_q      <= pat_n;
      len_q      <= len_n;
      div_q      <= div_n;
      reps_q     <= reps_n;
      k          <= k_n;
      dcnt       <= dcnt_n;
      rcnt       <= rcnt_n;
      gcnt       <= gcnt_n;
      xs         <= xs_n;
      busy       <= (state_n == S_SHIFT) || (state_n == S_GAP);
      bit_strobe <= (state_n == S_SHIFT) && (dcnt_n == '0);
      done       <= (state_n == S_DONE);
      // DONE is counted too, to catch the detector's one-cycle output lag.
      if (state == S_IDLE && start) begin
        hits <= '0;
      end else if (state != S_IDLE && fin && hits != '1) begin
        hits <= hits + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sd_pattern_gen.sv
// tb/tb_sd_pattern_gen.sv - directed self-checking bench for sd_pattern_gen
module tb_sd_pattern_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] div;
  logic [3:0] reps;
  logic       fin;
  logic       xs;
  logic       busy;
  logic       bit_strobe;
  logic       done;
  logic [3:0] hits;

  int n_checks = 0;
  int n_errors = 0;

  sd_pattern_gen #(
    .PAT_W(8), .DIV_W(4), .REP_W(4), .GAP_CYC(2), .HIT_W(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pattern(pattern), .len(len), .div(div), .reps(reps), .fin(fin),
    .xs(xs), .busy(busy), .bit_strobe(bit_strobe), .done(done), .hits(hits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_start(input logic [7:0] p, input logic [3:0] l,
                          input logic [3:0] d, input logic [3:0] r);
    pattern = p;
    len     = l;
    div     = d;
    reps    = r;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Walks a whole run: n busy cycles, then the done cycle, then one idle cycle.
  task automatic expect_serial(input string tag, input logic [31:0] xs_exp,
                               input logic [31:0] stb_exp, input int n, input bit poke);
    for (int i = 0; i < n; i++) begin
      check({tag, "_xs"}, xs, xs_exp[n-1-i]);
      check({tag, "_busy"}, busy, 1);
      check({tag, "_stb"}, bit_strobe, stb_exp[n-1-i]);
      check({tag, "_done_early"}, done, 0);
      start = poke && (i == 2);
      if (poke) pattern = 8'hFF;
      tick();
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_xs_end"}, xs, 0);
    start = poke;
    tick();
    start = 1'b0;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; fin = 1'b0;
    pattern = '0; len = '0; div = '0; reps = '0;
    tick();
    tick();
    check("rst_xs", xs, 0);
    check("rst_busy", busy, 0);
    check("rst_stb", bit_strobe, 0);
    check("rst_done", done, 0);
    check("rst_hits", hits, 0);
    reset = 1'b1;
    tick();

    // Single 8-bit frame
    do_start(8'b1011_0110, 4'd8, 4'd0, 4'd0);
    expect_serial("single", 32'b1011_0110, 32'hFF, 8, 1'b0);

    // 3-bit frame, div=1, one repeat, 2-cycle gap
    do_start(8'h05, 4'd3, 4'd1, 4'd1);
    expect_serial("short", 32'b11_0011_0011_0011, 32'b10_1010_0010_1010, 14, 1'b0);

    // Length clamp
    do_start(8'hC5, 4'd0, 4'd0, 4'd0);
    expect_serial("len0", 32'hC5, 32'hFF, 8, 1'b0);
    do_start(8'h3A, 4'd15, 4'd0, 4'd0);
    expect_serial("len15", 32'h3A, 32'hFF, 8, 1'b0);

    // Hit counting, including the DONE cycle
    do_start(8'hB6, 4'd8, 4'd0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      fin = (i == 1) || (i == 3) || (i == 5);
      tick();
    end
    fin = 1'b1;
    check("hit_done", done, 1);
    tick();
    fin = 1'b0;
    check("hit_after_done", hits, 4);
    tick();
    check("hit_idle_hold", hits, 4);

    // Saturation
    do_start(8'hB6, 4'd8, 4'd0, 4'd3);
    check("sat_clear", hits, 0);
    fin = 1'b1;
    repeat (20) tick();
    fin = 1'b0;
    check("sat_hits", hits, 15);
    begin
      int w = 0;
      while (!done && w < 100) begin
        tick();
        w++;
      end
    end
    check("sat_done_seen", done, 1);
    tick();
    check("sat_hits_idle", hits, 15);

    // Abort mid-frame; hits kept, then a restart clears them
    do_start(8'hB6, 4'd8, 4'd0, 4'd0);
    fin = 1'b1;
    tick();
    tick();
    fin = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_xs", xs, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hits", hits, 2);
    tick();
    check("abort_no_done", done, 0);
    do_start(8'hB6, 4'd8, 4'd0, 4'd0);
    check("restart_hits", hits, 0);
    expect_serial("restart", 32'hB6, 32'hFF, 8, 1'b0);

    // Reset in the middle of a gap
    do_start(8'h05, 4'd3, 4'd1, 4'd1);
    fin = 1'b1;
    repeat (6) tick();
    check("gap_busy", busy, 1);
    check("gap_xs", xs, 0);
    check("gap_hits", hits, 6);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    fin = 1'b0;
    check("midrst_xs", xs, 0);
    check("midrst_busy", busy, 0);
    check("midrst_stb", bit_strobe, 0);
    check("midrst_done", done, 0);
    check("midrst_hits", hits, 0);
    tick();
    check("midrst_stays_idle", busy, 0);

    // Start pulses during SHIFT and DONE are ignored
    do_start(8'b1011_0110, 4'd8, 4'd0, 4'd0);
    expect_serial("ignore", 32'b1011_0110, 32'hFF, 8, 1'b1);
    tick();
    check("ignore_no_rerun", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
